// File: rtl/axis_bram_stream_writer_pkg.sv
// Shared definitions for the AXI-Stream to BRAM writer: FSM encoding and
// the legal upper bound of the delay-line length.
package axis_bram_stream_writer_pkg;

    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StFull = 1'b1
    } wr_state_e;

    localparam int unsigned MaxDelay = 64;

endpackage

// File: rtl/bram_wr_delay_line.sv
// Fixed-latency shift register carrying a payload plus a valid flag.
// Only the valid bits are reset; payload registers are free-running.
module bram_wr_delay_line #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic [Depth-1:0] valid_q;
    logic [Width-1:0] data_q [Depth];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            for (int unsigned i = 1; i < Depth; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        data_q[0] <= data_i;
        for (int unsigned i = 1; i < Depth; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign valid_o = valid_q[Depth-1];
    assign data_o  = data_q[Depth-1];

endmodule

// File: rtl/axis_bram_stream_writer.sv
// AXI-Stream slave that writes each accepted beat to a BRAM port after a
// fixed latency, with wrap-around or stop-when-full pointer handling.
module axis_bram_stream_writer
    import axis_bram_stream_writer_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned DELAY     = 16,
    parameter int unsigned WRAP_MODE = 1
) (
    input  logic                s00_axis_aclk,
    input  logic                s00_axis_aresetn,
    input  logic                s00_axis_tvalid,
    output logic                s00_axis_tready,
    input  logic                s00_axis_tlast,
    input  logic [DATA_W-1:0]   s00_axis_tdata,
    input  logic [DATA_W/8-1:0] s00_axis_tstrb,
    input  logic                bram_restart,
    output logic                bram_clk,
    output logic                bram_en,
    output logic [DATA_W/8-1:0] bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [DATA_W-1:0]   bram_din,
    output logic                frame_done,
    output logic                buf_full,
    output logic [ADDR_W:0]     beat_count
);

    localparam int unsigned StrbW = DATA_W / 8;
    localparam int unsigned LineW = DATA_W + StrbW + 1 + ADDR_W;
    localparam logic [ADDR_W:0] CntFull   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CntFullM1 = {1'b0, {ADDR_W{1'b1}}};

    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 8");
    end
    if (DELAY > MaxDelay) begin : g_bad_delay
        $error("DELAY out of range");
    end

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    logic              accept;
    logic [ADDR_W-1:0] cap_addr;
    logic              line_valid;
    logic [LineW-1:0]  line_data;
    logic [DATA_W-1:0] line_din;
    logic [StrbW-1:0]  line_strb;
    logic              line_last;
    logic [ADDR_W-1:0] line_addr;

    assign s00_axis_tready = (state_q == StRun) && s00_axis_aresetn;
    assign accept          = s00_axis_tvalid && s00_axis_tready;
    // A restart coinciding with an acceptance binds that beat to address 0.
    assign cap_addr        = bram_restart ? '0 : wr_ptr_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (bram_restart) begin
            state_d  = StRun;
            wr_ptr_d = accept ? ADDR_W'(1) : '0;
            cnt_d    = accept ? (ADDR_W + 1)'(1) : '0;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (cnt_q != CntFull) begin
                cnt_d = cnt_q + (ADDR_W + 1)'(1);
            end
            if (WRAP_MODE == 0 && cnt_q == CntFullM1) begin
                state_d = StFull;
            end
        end
    end

    bram_wr_delay_line #(
        .Width(LineW),
        .Depth(DELAY + 1)
    ) u_delay_line (
        .clk_i  (s00_axis_aclk),
        .rst_ni (s00_axis_aresetn),
        .valid_i(accept),
        .data_i ({s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast, cap_addr}),
        .valid_o(line_valid),
        .data_o (line_data)
    );

    assign {line_din, line_strb, line_last, line_addr} = line_data;

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            state_q    <= StRun;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            bram_en    <= 1'b0;
            bram_we    <= '0;
            bram_addr  <= '0;
            bram_din   <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            bram_en    <= 1'b1;
            frame_done <= line_valid && line_last;
            if (line_valid) begin
                bram_we   <= line_strb;
                bram_addr <= line_addr;
                bram_din  <= line_din;
            end else begin
                bram_we <= '0;
            end
        end
    end

    assign bram_clk   = s00_axis_aclk;
    assign buf_full   = (state_q == StFull);
    assign beat_count = cnt_q;

endmodule

// File: tb/tb_axis_bram_stream_writer.sv
// Directed bench: three writer instances (default, 8-deep stop mode, 8-deep wrap mode)
// share the stream inputs; each task checks the instance its scenario targets.
module tb_axis_bram_stream_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, tvalid, tlast, restart;
    logic [31:0] tdata;
    logic [3:0]  tstrb;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic        a_tready, a_bclk, a_en, a_fd, a_full;
    logic [3:0]  a_we;
    logic [12:0] a_addr;
    logic [31:0] a_din;
    logic [13:0] a_cnt;
    logic        s_tready, s_bclk, s_en, s_fd, s_full;
    logic [3:0]  s_we;
    logic [2:0]  s_addr;
    logic [31:0] s_din;
    logic [3:0]  s_cnt;
    logic        w_tready, w_bclk, w_en, w_fd, w_full;
    logic [3:0]  w_we;
    logic [2:0]  w_addr;
    logic [31:0] w_din;
    logic [3:0]  w_cnt;

    axis_bram_stream_writer u_dut_a (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s00_axis_tvalid(tvalid),
        .s00_axis_tready(a_tready), .s00_axis_tlast(tlast), .s00_axis_tdata(tdata),
        .s00_axis_tstrb(tstrb), .bram_restart(restart), .bram_clk(a_bclk), .bram_en(a_en),
        .bram_we(a_we), .bram_addr(a_addr), .bram_din(a_din), .frame_done(a_fd),
        .buf_full(a_full), .beat_count(a_cnt)
    );

    axis_bram_stream_writer #(.DATA_W(32), .ADDR_W(3), .DELAY(2), .WRAP_MODE(0)) u_dut_s (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s00_axis_tvalid(tvalid),
        .s00_axis_tready(s_tready), .s00_axis_tlast(tlast), .s00_axis_tdata(tdata),
        .s00_axis_tstrb(tstrb), .bram_restart(restart), .bram_clk(s_bclk), .bram_en(s_en),
        .bram_we(s_we), .bram_addr(s_addr), .bram_din(s_din), .frame_done(s_fd),
        .buf_full(s_full), .beat_count(s_cnt)
    );

    axis_bram_stream_writer #(.DATA_W(32), .ADDR_W(3), .DELAY(0), .WRAP_MODE(1)) u_dut_w (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n), .s00_axis_tvalid(tvalid),
        .s00_axis_tready(w_tready), .s00_axis_tlast(tlast), .s00_axis_tdata(tdata),
        .s00_axis_tstrb(tstrb), .bram_restart(restart), .bram_clk(w_bclk), .bram_en(w_en),
        .bram_we(w_we), .bram_addr(w_addr), .bram_din(w_din), .frame_done(w_fd),
        .buf_full(w_full), .beat_count(w_cnt)
    );

    int          a_cyc_q[$];
    logic [12:0] a_addr_q[$];
    logic [31:0] a_din_q[$];
    logic [3:0]  a_we_q[$];
    int          a_fd_q[$];
    logic [2:0]  s_addr_q[$];
    logic [31:0] s_din_q[$];
    logic [2:0]  w_addr_q[$];
    logic [31:0] w_din_q[$];
    int          w_cyc_q[$];
    int          w_fd_q[$];

    // Record every BRAM write cycle and frame_done pulse with its cycle number.
    always @(negedge clk) begin
        if (a_we != 4'h0) begin
            a_cyc_q.push_back(cyc);
            a_addr_q.push_back(a_addr);
            a_din_q.push_back(a_din);
            a_we_q.push_back(a_we);
        end
        if (a_fd === 1'b1) a_fd_q.push_back(cyc);
        if (s_we != 4'h0) begin
            s_addr_q.push_back(s_addr);
            s_din_q.push_back(s_din);
        end
        if (w_we != 4'h0) begin
            w_addr_q.push_back(w_addr);
            w_din_q.push_back(w_din);
            w_cyc_q.push_back(cyc);
        end
        if (w_fd === 1'b1) w_fd_q.push_back(cyc);
    end

    task automatic clear_q();
        a_cyc_q.delete(); a_addr_q.delete(); a_din_q.delete(); a_we_q.delete();
        a_fd_q.delete(); s_addr_q.delete(); s_din_q.delete();
        w_addr_q.delete(); w_din_q.delete(); w_cyc_q.delete(); w_fd_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; restart = 1'b0; tdata = '0; tstrb = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_q();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] s, input logic l);
        tvalid = 1'b1; tdata = d; tstrb = s; tlast = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0; tlast = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tvalid = 1'b1; tlast = 1'b1; restart = 1'b0; tdata = 32'hFFFF_FFFF;
        tstrb = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({a_tready, s_tready, w_tready} !== 3'b000)
            $display("FAIL reset_tready got %b want 000", {a_tready, s_tready, w_tready});
        else n_pass++;
        n_checks++;
        if ({a_en, s_en, w_en} !== 3'b000)
            $display("FAIL reset_en got %b want 000", {a_en, s_en, w_en});
        else n_pass++;
        n_checks++;
        if ({a_we, a_addr, a_din, a_fd, a_full, a_cnt, s_we, s_fd, s_full, s_cnt} !== '0)
            $display("FAIL reset_outputs we=%h addr=%h din=%h fd=%b full=%b cnt=%0d want all 0",
                     a_we, a_addr, a_din, a_fd, a_full, a_cnt);
        else n_pass++;
        n_checks++;
        if ({a_bclk, s_bclk, w_bclk} !== 3'b000)
            $display("FAIL bram_clk got %b want 000 on low clock phase", {a_bclk, s_bclk, w_bclk});
        else n_pass++;
        rst_n = 1'b1; tvalid = 1'b0; tlast = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({a_en, s_en, w_en, a_tready} !== 4'b1111)
            $display("FAIL post_reset_en_tready got %b want 1111", {a_en, s_en, w_en, a_tready});
        else n_pass++;
        #1 clear_q();
    endtask

    task automatic test_basic();
        int acc0 = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(32'hA0 + 32'(i), 4'hF, 1'b0);
            if (i == 0) acc0 = cyc;
        end
        idle(20);
        n_checks++;
        if (a_addr_q.size() != 4) $display("FAIL basic_count got %0d want 4", a_addr_q.size());
        else n_pass++;
        for (int i = 0; i < a_addr_q.size() && i < 4; i++) begin
            n_checks++;
            if (a_addr_q[i] !== 13'(i) || a_din_q[i] !== 32'hA0 + 32'(i) || a_we_q[i] !== 4'hF
                || a_cyc_q[i] != acc0 + 17 + i)
                $display("FAIL basic_write%0d got addr=%0d din=%h we=%h cyc=%0d want %0d %h f %0d",
                         i, a_addr_q[i], a_din_q[i], a_we_q[i], a_cyc_q[i], i, 32'hA0 + i,
                         acc0 + 17 + i);
            else n_pass++;
        end
        n_checks++;
        if (a_cnt !== 14'd4) $display("FAIL basic_beat_count got %0d want 4", a_cnt);
        else n_pass++;
    endtask

    task automatic test_strobe();
        do_reset();
        idle(20);
        n_checks++;
        if (a_addr_q.size() != 0) $display("FAIL idle_no_write got %0d writes want 0", a_addr_q.size());
        else n_pass++;
        send(32'h55, 4'h5, 1'b0);
        idle(19);
        n_checks++;
        if (a_we_q.size() != 1 || a_we_q[0] !== 4'h5 || a_addr_q[0] !== 13'd0 || a_din_q[0] !== 32'h55)
            $display("FAIL strobe_write got n=%0d we=%h want n=1 we=5 addr=0 din=55",
                     a_we_q.size(), a_we_q.size() > 0 ? a_we_q[0] : 4'hx);
        else n_pass++;
    endtask

    task automatic test_stop();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (s_tready !== 1'b1) $display("FAIL stop_tready%0d got %b want 1", i, s_tready);
            else n_pass++;
            send(32'h10 + 32'(i), 4'hF, 1'b0);
        end
        n_checks++;
        if ({s_tready, s_full, s_cnt} !== {1'b0, 1'b1, 4'd8})
            $display("FAIL stop_full got tready=%b full=%b cnt=%0d want 0 1 8", s_tready, s_full, s_cnt);
        else n_pass++;
        tvalid = 1'b1; tdata = 32'h99;
        @(posedge clk);
        #1;
        n_checks++;
        if ({s_tready, s_cnt} !== {1'b0, 4'd8})
            $display("FAIL stop_hold got tready=%b cnt=%0d want 0 8", s_tready, s_cnt);
        else n_pass++;
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        n_checks++;
        if ({s_tready, s_full, s_cnt} !== {1'b1, 1'b0, 4'd0})
            $display("FAIL stop_restart got tready=%b full=%b cnt=%0d want 1 0 0", s_tready, s_full, s_cnt);
        else n_pass++;
        @(posedge clk);
        #1;
        idle(5);
        n_checks++;
        if (s_cnt !== 4'd1) $display("FAIL stop_count_after got %0d want 1", s_cnt);
        else n_pass++;
        n_checks++;
        if (s_addr_q.size() != 9 || s_addr_q[8] !== 3'd0 || s_din_q[8] !== 32'h99)
            $display("FAIL stop_ninth got n=%0d want 9 writes, last at addr 0 data 99", s_addr_q.size());
        else n_pass++;
        for (int i = 0; i < s_addr_q.size() && i < 8; i++) begin
            n_checks++;
            if (s_addr_q[i] !== 3'(i) || s_din_q[i] !== 32'h10 + 32'(i))
                $display("FAIL stop_write%0d got addr=%0d din=%h want %0d %h",
                         i, s_addr_q[i], s_din_q[i], i, 32'h10 + i);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        int acc0 = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(32'h20 + 32'(i), 4'hF, 1'b0);
            if (i == 0) acc0 = cyc;
        end
        idle(3);
        n_checks++;
        if (w_addr_q.size() != 10) $display("FAIL wrap_count got %0d want 10", w_addr_q.size());
        else n_pass++;
        for (int i = 0; i < w_addr_q.size() && i < 10; i++) begin
            n_checks++;
            if (w_addr_q[i] !== 3'(i) || w_din_q[i] !== 32'h20 + 32'(i) || w_cyc_q[i] != acc0 + 1 + i)
                $display("FAIL wrap_write%0d got addr=%0d din=%h cyc=%0d want %0d %h %0d",
                         i, w_addr_q[i], w_din_q[i], w_cyc_q[i], i % 8, 32'h20 + i, acc0 + 1 + i);
            else n_pass++;
        end
        n_checks++;
        if ({w_cnt, w_full, w_tready} !== {4'd8, 1'b0, 1'b1})
            $display("FAIL wrap_state got cnt=%0d full=%b tready=%b want 8 0 1", w_cnt, w_full, w_tready);
        else n_pass++;
    endtask

    task automatic test_restart_coincident();
        int          acc0 = 0;
        logic [12:0] exp_addr [5] = '{13'd5, 13'd6, 13'd7, 13'd0, 13'd1};
        logic [31:0] exp_din  [5] = '{32'hC5, 32'hC6, 32'hC7, 32'hBB, 32'hCC};
        do_reset();
        for (int i = 0; i < 5; i++) send(32'hC0 + 32'(i), 4'hF, 1'b0);
        idle(20);
        clear_q();
        for (int i = 0; i < 3; i++) begin
            send(32'hC5 + 32'(i), 4'hF, 1'b0);
            if (i == 0) acc0 = cyc;
        end
        restart = 1'b1;
        send(32'hBB, 4'hF, 1'b0);
        restart = 1'b0;
        n_checks++;
        if ({a_cnt, a_full} !== {14'd1, 1'b0})
            $display("FAIL coincident_count got cnt=%0d full=%b want 1 0", a_cnt, a_full);
        else n_pass++;
        send(32'hCC, 4'hF, 1'b0);
        idle(20);
        n_checks++;
        if (a_addr_q.size() != 5) $display("FAIL coincident_writes got %0d want 5", a_addr_q.size());
        else n_pass++;
        for (int i = 0; i < a_addr_q.size() && i < 5; i++) begin
            n_checks++;
            if (a_addr_q[i] !== exp_addr[i] || a_din_q[i] !== exp_din[i] || a_cyc_q[i] != acc0 + 17 + i)
                $display("FAIL coincident_write%0d got addr=%0d din=%h cyc=%0d want %0d %h %0d",
                         i, a_addr_q[i], a_din_q[i], a_cyc_q[i], exp_addr[i], exp_din[i], acc0 + 17 + i);
            else n_pass++;
        end
    endtask

    task automatic test_reset_inflight();
        int acc0 = 0;
        do_reset();
        for (int i = 0; i < 5; i++) send(32'hD0 + 32'(i), 4'hF, 1'b1);
        idle(3);
        clear_q();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({a_tready, a_en, a_we, a_addr, a_din, a_fd, a_full, a_cnt} !== '0)
            $display("FAIL midreset_outputs got en=%b we=%h addr=%h din=%h cnt=%0d want all 0",
                     a_en, a_we, a_addr, a_din, a_cnt);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(25);
        n_checks++;
        if (a_addr_q.size() != 0 || a_fd_q.size() != 0)
            $display("FAIL midreset_discard got %0d writes %0d pulses want 0 0",
                     a_addr_q.size(), a_fd_q.size());
        else n_pass++;
        send(32'hE0, 4'hF, 1'b0);
        acc0 = cyc;
        send(32'hE1, 4'hF, 1'b1);
        send(32'hE2, 4'hF, 1'b0);
        idle(20);
        n_checks++;
        if (a_addr_q.size() != 3) $display("FAIL frame_writes got %0d want 3", a_addr_q.size());
        else n_pass++;
        n_checks++;
        if (a_fd_q.size() != 1 || a_fd_q[0] != acc0 + 18)
            $display("FAIL frame_done got n=%0d cyc=%0d want 1 pulse at %0d", a_fd_q.size(),
                     a_fd_q.size() > 0 ? a_fd_q[0] : -1, acc0 + 18);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc0 = 0;
        do_reset();
        send(32'hF0, 4'hF, 1'b1);
        acc0 = cyc;
        send(32'hF1, 4'hF, 1'b1);
        send(32'hF2, 4'hF, 1'b0);
        idle(3);
        n_checks++;
        if (w_fd_q.size() != 2 || w_fd_q[0] != acc0 + 1 || w_fd_q[1] != acc0 + 2)
            $display("FAIL back_to_back_done got n=%0d first=%0d want 2 pulses at %0d,%0d",
                     w_fd_q.size(), w_fd_q.size() > 0 ? w_fd_q[0] : -1, acc0 + 1, acc0 + 2);
        else n_pass++;
        n_checks++;
        if (w_cyc_q.size() != 3 || w_cyc_q[2] != acc0 + 3 || w_din_q[2] !== 32'hF2)
            $display("FAIL back_to_back_writes got n=%0d want 3 consecutive writes", w_cyc_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_stop();
        test_wrap();
        test_restart_coincident();
        test_reset_inflight();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
